// File: rtl/isa_pkg.sv
// miniMips ISA encodings and the decoded control bundle.
// Shared by the decode stage and its field decoder.
package isa_pkg;

  typedef enum logic [2:0] {
    OP_STR    = 3'b000,
    OP_LDR    = 3'b001,
    OP_MOV    = 3'b010,
    OP_SHIFT  = 3'b011,
    OP_SADDTO = 3'b100,
    OP_BLT    = 3'b101,
    OP_XOR    = 3'b110,
    OP_AND    = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_UADD   = 3'b000,
    ALU_AND    = 3'b001,
    ALU_XOR    = 3'b010,
    ALU_LSHIFT = 3'b011,
    ALU_RSHIFT = 3'b100,
    ALU_SADD   = 3'b101,
    ALU_LT     = 3'b110,
    ALU_SET    = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic    write_en;
    logic    mem_write;
    logic    mem_read;
    logic    use_alu_bypass;
    logic    alu_src;
    alu_op_t alu_op;
  } ctrl_t;

  localparam int CNT_W = 4;
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_stage_instr_fields.sv
// Combinational field decoder: raw instr to control
// bundle, addresses, immediate and source registers.
import isa_pkg::*;

module instr_fields #(
  parameter  int REG_AW  = 2,
  parameter  int IMM_W   = 8,
  localparam int INSTR_W = 3 + 3 * REG_AW
) (
  input  logic [INSTR_W-1:0] i_instr,
  output ctrl_t              o_ctrl,
  output logic [REG_AW-1:0]  o_ar1,
  output logic [REG_AW-1:0]  o_ar2,
  output logic [REG_AW-1:0]  o_ar3,
  output logic [IMM_W-1:0]   o_imm,
  output logic [REG_AW-1:0]  o_src0,
  output logic [REG_AW-1:0]  o_src1,
  output logic [1:0]         o_src_v,
  output logic               o_is_ldr,
  output logic               o_uadd
);

  localparam int FW = 2 * REG_AW;

  opcode_t           w_opc;
  logic [REG_AW-1:0] w_f3;
  logic [REG_AW-1:0] w_f1;
  logic [REG_AW-1:0] w_f0;
  logic [FW-1:0]     w_fld;
  logic [FW-1:0]     w_neg;

  assign w_opc = opcode_t'(i_instr[INSTR_W-1 -: 3]);
  assign w_f3  = i_instr[3*REG_AW-1 -: REG_AW];
  assign w_f1  = i_instr[2*REG_AW-1 -: REG_AW];
  assign w_f0  = i_instr[REG_AW-1:0];
  assign w_fld = {w_f1, w_f0};
  assign w_neg = -w_fld;

  assign o_is_ldr = (w_opc == OP_LDR);
  assign o_uadd   = (w_opc == OP_SADDTO)
                  & w_f3[REG_AW-1];

  // Per-opcode decode; unused fields stay zero.
  always_comb begin
    o_ctrl  = CTRL_NOP;
    o_ar1   = '0;
    o_ar2   = '0;
    o_ar3   = '0;
    o_imm   = '0;
    o_src0  = w_f1;
    o_src1  = w_f0;
    o_src_v = 2'b00;
    unique case (w_opc)
      OP_STR, OP_LDR: begin
        o_ar1          = w_f1;
        o_ar3          = w_f3;
        o_imm          = IMM_W'(w_f0);
        o_ctrl.alu_op  = ALU_UADD;
        o_ctrl.alu_src = 1'b1;
        if (w_opc == OP_STR) begin
          o_ctrl.mem_write = 1'b1;
          o_src1           = w_f3;
          o_src_v          = 2'b11;
        end else begin
          o_ctrl.mem_read = 1'b1;
          o_ctrl.write_en = 1'b1;
          o_src_v         = 2'b01;
        end
      end
      OP_MOV: begin
        o_ar3                 = w_f3;
        o_imm                 = IMM_W'(w_fld);
        o_ctrl.alu_op         = ALU_SET;
        o_ctrl.alu_src        = 1'b1;
        o_ctrl.use_alu_bypass = 1'b1;
        o_ctrl.write_en       = 1'b1;
      end
      OP_SHIFT: begin
        o_ar3                 = w_f3;
        o_ctrl.alu_src        = 1'b1;
        o_ctrl.use_alu_bypass = 1'b1;
        o_ctrl.write_en       = 1'b1;
        if (w_fld[FW-1]) begin
          o_ctrl.alu_op = ALU_RSHIFT;
          o_imm         = IMM_W'(w_neg);
        end else begin
          o_ctrl.alu_op = ALU_LSHIFT;
          o_imm         = IMM_W'(w_fld);
        end
      end
      OP_SADDTO: begin
        o_ar1                 = w_f1;
        o_ar2                 = w_f0;
        o_ar3                 = w_f1;
        o_ctrl.write_en       = 1'b1;
        o_ctrl.use_alu_bypass = 1'b1;
        o_ctrl.alu_op         = w_f3[REG_AW-1]
                              ? ALU_UADD : ALU_SADD;
        o_src_v               = 2'b11;
      end
      OP_BLT: begin
        o_ar1         = w_f1;
        o_ar2         = w_f0;
        o_ar3         = w_f3;
        o_ctrl.alu_op = ALU_LT;
        o_src_v       = 2'b11;
      end
      OP_XOR, OP_AND: begin
        o_ar1                 = w_f1;
        o_ar2                 = w_f0;
        o_ar3                 = w_f3;
        o_ctrl.write_en       = 1'b1;
        o_ctrl.use_alu_bypass = 1'b1;
        o_ctrl.alu_op         = (w_opc == OP_XOR)
                              ? ALU_XOR : ALU_AND;
        o_src_v               = 2'b11;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: handshake, load-use
// scoreboard, carry-chain flag and flush.
import isa_pkg::*;

module decode_stage #(
  parameter  int REG_AW   = 2,
  parameter  int IMM_W    = 8,
  parameter  int LOAD_LAT = 2,
  localparam int INSTR_W  = 3 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  ar1,
  output logic [REG_AW-1:0]  ar2,
  output logic [REG_AW-1:0]  ar3,
  output logic               write_en,
  output logic               mem_write,
  output logic               mem_read,
  output logic               use_alu_bypass,
  output logic               alu_src,
  output logic               car,
  output logic [IMM_W-1:0]   imm,
  output logic [2:0]         alu_op
);

  localparam int NREG = 1 << REG_AW;

  ctrl_t             w_ctrl;
  logic [REG_AW-1:0] w_ar1;
  logic [REG_AW-1:0] w_ar2;
  logic [REG_AW-1:0] w_ar3;
  logic [IMM_W-1:0]  w_imm;
  logic [REG_AW-1:0] w_src0;
  logic [REG_AW-1:0] w_src1;
  logic [1:0]        w_src_v;
  logic              w_is_ldr;
  logic              w_uadd;
  logic              w_hazard;
  logic              w_acc;

  logic [CNT_W-1:0]  r_cnt [NREG];
  ctrl_t             r_ctrl;
  logic [REG_AW-1:0] r_ar1;
  logic [REG_AW-1:0] r_ar2;
  logic [REG_AW-1:0] r_ar3;
  logic [IMM_W-1:0]  r_imm;
  logic              r_car;
  logic              r_chain;
  logic              r_out_valid;

  instr_fields #(
    .REG_AW (REG_AW),
    .IMM_W  (IMM_W)
  ) u_fields (
    .i_instr  (instr),
    .o_ctrl   (w_ctrl),
    .o_ar1    (w_ar1),
    .o_ar2    (w_ar2),
    .o_ar3    (w_ar3),
    .o_imm    (w_imm),
    .o_src0   (w_src0),
    .o_src1   (w_src1),
    .o_src_v  (w_src_v),
    .o_is_ldr (w_is_ldr),
    .o_uadd   (w_uadd)
  );

  assign w_hazard = in_valid & (
      (w_src_v[0] & (r_cnt[w_src0] != '0))
    | (w_src_v[1] & (r_cnt[w_src1] != '0)));

  assign in_ready = !flush & !w_hazard
                  & (!r_out_valid | out_ready);
  assign w_acc    = in_valid & in_ready;

  // Busy counters: a new load overrides the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_acc && w_is_ldr
            && w_ar3 == REG_AW'(i))
          r_cnt[i] <= CNT_W'(LOAD_LAT);
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Output register and carry-chain flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_chain     <= 1'b0;
      r_car       <= 1'b0;
      r_ctrl      <= CTRL_NOP;
      r_ar1       <= '0;
      r_ar2       <= '0;
      r_ar3       <= '0;
      r_imm       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_chain     <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_chain     <= w_uadd;
      r_car       <= w_uadd & r_chain;
      r_ctrl      <= w_ctrl;
      r_ar1       <= w_ar1;
      r_ar2       <= w_ar2;
      r_ar3       <= w_ar3;
      r_imm       <= w_imm;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign ar1            = r_ar1;
  assign ar2            = r_ar2;
  assign ar3            = r_ar3;
  assign imm            = r_imm;
  assign car            = r_car;
  assign write_en       = r_ctrl.write_en;
  assign mem_write      = r_ctrl.mem_write;
  assign mem_read       = r_ctrl.mem_read;
  assign use_alu_bypass = r_ctrl.use_alu_bypass;
  assign alu_src        = r_ctrl.alu_src;
  assign alu_op         = r_ctrl.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage.
// Random + directed stimulus against a behavioural model.
module tb_decode_stage;

  localparam int RA  = 2;
  localparam int IW  = 8;
  localparam int LAT = 2;
  localparam int INW = 3 + 3 * RA;
  localparam int NR  = 1 << RA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [INW-1:0] instr = '0;
  logic in_ready, out_valid;
  logic [RA-1:0] ar1, ar2, ar3;
  logic write_en, mem_write, mem_read;
  logic use_alu_bypass, alu_src, car;
  logic [IW-1:0] imm;
  logic [2:0] alu_op;

  logic u2_vld = 1'b0;
  logic [11:0] u2_ins = '0;
  logic u2_rdy, u2_ov, u2_we, u2_mw, u2_mr;
  logic u2_byp, u2_src, u2_car;
  logic [2:0] u2_a1, u2_a2, u2_a3, u2_alu;
  logic [7:0] u2_imm;

  always #5 clk = ~clk;

  decode_stage #(
    .REG_AW(RA), .IMM_W(IW), .LOAD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid),
    .out_ready(out_ready),
    .ar1(ar1), .ar2(ar2), .ar3(ar3),
    .write_en(write_en), .mem_write(mem_write),
    .mem_read(mem_read),
    .use_alu_bypass(use_alu_bypass),
    .alu_src(alu_src), .car(car), .imm(imm),
    .alu_op(alu_op)
  );

  decode_stage #(
    .REG_AW(3), .IMM_W(8), .LOAD_LAT(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(u2_vld), .in_ready(u2_rdy),
    .instr(u2_ins), .out_valid(u2_ov),
    .out_ready(1'b1),
    .ar1(u2_a1), .ar2(u2_a2), .ar3(u2_a3),
    .write_en(u2_we), .mem_write(u2_mw),
    .mem_read(u2_mr), .use_alu_bypass(u2_byp),
    .alu_src(u2_src), .car(u2_car), .imm(u2_imm),
    .alu_op(u2_alu)
  );

  typedef struct packed {
    logic          we, mw, mr, byp, src;
    logic [2:0]    alu;
    logic [RA-1:0] a1, a2, a3;
    logic [IW-1:0] imm;
  } exp_t;

  exp_t m_out;
  bit   m_ov, m_chain, m_car, last_rdy;
  int   m_ready_at [NR];
  int   cyc;
  int   n_chk, n_pass;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic exp_t ref_dec(input logic [INW-1:0] ins);
    exp_t e;
    int op, fld, sp;
    logic [RA-1:0] f3, f1, f0;
    op  = int'(ins[INW-1 -: 3]);
    f3  = ins[3*RA-1 -: RA];
    f1  = ins[2*RA-1 -: RA];
    f0  = ins[RA-1:0];
    fld = int'(f1) * NR + int'(f0);
    sp  = NR * NR;
    e   = '0;
    case (op)
      0, 1: begin
        e.a1 = f1; e.a3 = f3; e.imm = IW'(f0);
        e.src = 1'b1;
        if (op == 0) e.mw = 1'b1;
        else begin e.mr = 1'b1; e.we = 1'b1; end
      end
      2: begin
        e.a3 = f3; e.imm = IW'(fld); e.alu = 3'd7;
        e.src = 1'b1; e.byp = 1'b1; e.we = 1'b1;
      end
      3: begin
        e.a3 = f3; e.src = 1'b1;
        e.byp = 1'b1; e.we = 1'b1;
        if (fld >= sp / 2) begin
          e.alu = 3'd4; e.imm = IW'((sp - fld) % sp);
        end else begin
          e.alu = 3'd3; e.imm = IW'(fld);
        end
      end
      4: begin
        e.a1 = f1; e.a2 = f0; e.a3 = f1;
        e.we = 1'b1; e.byp = 1'b1;
        e.alu = f3[RA-1] ? 3'd0 : 3'd5;
      end
      5: begin
        e.a1 = f1; e.a2 = f0; e.a3 = f3; e.alu = 3'd6;
      end
      default: begin
        e.a1 = f1; e.a2 = f0; e.a3 = f3;
        e.we = 1'b1; e.byp = 1'b1;
        e.alu = (op == 6) ? 3'd2 : 3'd1;
      end
    endcase
    return e;
  endfunction

  function automatic bit busy(input logic [RA-1:0] r);
    return cyc < m_ready_at[int'(r)];
  endfunction

  function automatic bit m_rdy();
    int op;
    bit hz;
    logic [RA-1:0] f3, f1, f0;
    op = int'(instr[INW-1 -: 3]);
    f3 = instr[3*RA-1 -: RA];
    f1 = instr[2*RA-1 -: RA];
    f0 = instr[RA-1:0];
    case (op)
      0:       hz = busy(f1) || busy(f3);
      1:       hz = busy(f1);
      2, 3:    hz = 1'b0;
      default: hz = busy(f1) || busy(f0);
    endcase
    hz = in_valid && hz;
    return !flush && !hz && (!m_ov || out_ready);
  endfunction

  task automatic model_reset();
    m_out = '0; m_ov = 0; m_chain = 0; m_car = 0;
    for (int r = 0; r < NR; r++) m_ready_at[r] = 0;
  endtask

  task automatic step();
    bit rdy, acc, uadd, ldr;
    exp_t d;
    logic [RA-1:0] f3;
    exp_t got;
    #1;
    rdy = m_rdy();
    last_rdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(rdy));
    acc  = in_valid && rdy;
    d    = ref_dec(instr);
    f3   = instr[3*RA-1 -: RA];
    uadd = (instr[INW-1 -: 3] == 3'd4) && f3[RA-1];
    ldr  = (instr[INW-1 -: 3] == 3'd1);
    @(posedge clk);
    cyc++;
    if (flush) begin
      m_ov = 0; m_chain = 0;
    end else if (acc) begin
      m_ov = 1; m_out = d;
      m_car = uadd && m_chain;
      m_chain = uadd;
      if (ldr) m_ready_at[int'(f3)] = cyc + LAT;
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      got = {write_en, mem_write, mem_read,
             use_alu_bypass, alu_src, alu_op,
             ar1, ar2, ar3, imm};
      check("bundle", 32'(got), 32'(m_out));
      check("car", 32'(car), 32'(m_car));
    end
  endtask

  task automatic cyc_do(input bit v,
                        input logic [INW-1:0] ins,
                        input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = v; instr = ins;
    out_ready = ordy; flush = fl;
    step();
  endtask

  localparam logic [INW-1:0] XOR0 = 9'b110_01_10_11;
  localparam logic [INW-1:0] LDR1 = 9'b001_01_00_00;
  localparam logic [INW-1:0] XR1  = 9'b110_00_01_00;
  localparam logic [INW-1:0] ANDI = 9'b111_11_10_01;
  localparam logic [INW-1:0] SAU  = 9'b100_10_01_10;
  localparam logic [INW-1:0] SAS  = 9'b100_00_01_10;

  initial begin
    int n;
    n_chk = 0; n_pass = 0; cyc = 0;
    model_reset();
    #12;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_bundle",
          32'({write_en, mem_write, mem_read,
               use_alu_bypass, alu_src, alu_op,
               ar1, ar2, ar3, imm, car}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);

    // second instance: REG_AW=3, LOAD_LAT=4
    @(negedge clk); u2_vld = 1'b1;
    u2_ins = 12'b001_001_000_000;
    #1 check("u2_ldr_rdy", 32'(u2_rdy), 32'd1);
    @(negedge clk); u2_ins = 12'b110_000_001_000;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (u2_rdy) break;
      n++;
      @(negedge clk);
    end
    check("u2_stall4", 32'(n), 32'd4);
    @(negedge clk); u2_vld = 1'b0;

    cyc_do(1, XOR0, 1, 0);
    check("xor_ar3", 32'(ar3), 32'd1);
    check("xor_ar1", 32'(ar1), 32'd2);
    check("xor_ar2", 32'(ar2), 32'd3);
    check("xor_op", 32'(alu_op), 32'd2);
    cyc_do(1, 9'b011_10_1110, 1, 0);
    check("shr_imm", 32'(imm), 32'd2);
    check("shr_op", 32'(alu_op), 32'd4);
    cyc_do(1, 9'b011_10_0011, 1, 0);
    check("shl_imm", 32'(imm), 32'd3);
    cyc_do(1, 9'b011_00_1000, 1, 0);
    check("shr8_imm", 32'(imm), 32'd8);

    cyc_do(1, LDR1, 1, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc_do(1, XR1, 1, 0);
      if (last_rdy) break;
      n++;
    end
    check("ldr_stall", 32'(n), 32'd2);

    cyc_do(1, XOR0, 1, 0);
    cyc_do(1, ANDI, 0, 0);
    cyc_do(1, ANDI, 0, 1);
    check("flush_ov", 32'(out_valid), 32'd0);
    cyc_do(1, ANDI, 0, 0);
    cyc_do(0, ANDI, 1, 0);

    cyc_do(1, SAU, 1, 0);
    check("car_first", 32'(car), 32'd0);
    cyc_do(1, SAU, 1, 0);
    check("car_second", 32'(car), 32'd1);
    cyc_do(1, XOR0, 1, 0);
    cyc_do(1, SAU, 1, 0);
    check("car_after_xor", 32'(car), 32'd0);
    cyc_do(0, SAU, 1, 1);
    cyc_do(1, SAU, 1, 0);
    check("car_after_flush", 32'(car), 32'd0);
    cyc_do(1, SAS, 1, 0);
    check("sadd_op", 32'(alu_op), 32'd5);
    check("sadd_car", 32'(car), 32'd0);

    for (int k = 0; k < 400; k++) begin
      cyc_do($urandom_range(0, 3) != 0,
             INW'($urandom),
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0);
    end

    // asynchronous reset in the middle of a stall
    cyc_do(1, LDR1, 1, 0);
    @(negedge clk);
    in_valid = 1'b1; instr = XR1; out_ready = 1'b1;
    #1 check("pre_rst_stall", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    cyc_do(1, XR1, 1, 0);
    cyc_do(0, XR1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
